// File: rtl/pp_pipeline_accel_divrem_pkg.sv
`default_nettype none
// ============================================================================
// Module  : pp_pipeline_accel_divrem_pkg
// Purpose : Shared widths, state encoding and helpers for the signed divider.
// Rev     : 1.0
// ============================================================================
package pp_pipeline_accel_divrem_pkg;

  localparam int DEF_DIVIDEND_W = 23;
  localparam int DEF_DIVISOR_W  = 10;

  function automatic int cnt_width(input int w);
    return $clog2(w);
  endfunction

  localparam int DEF_CNT_W = cnt_width(DEF_DIVIDEND_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage
`default_nettype wire

// File: rtl/pp_pipeline_accel_divrem_step.sv
`default_nettype none
// ============================================================================
// Module  : pp_pipeline_accel_divrem_step
// Purpose : One combinational restoring-division step on magnitudes.
// Rev     : 1.0
// ============================================================================
module pp_pipeline_accel_divrem_step
  import pp_pipeline_accel_divrem_pkg::*;
#(
  parameter int DIVISOR_W = DEF_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   prem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] dmag,
  output logic [DIVISOR_W:0]   prem_out,
  output logic                 qbit
);

  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W:0]   diff;

  assign shifted = {prem_in, bit_in};
  // When the subtract is taken, shifted < 2*|divisor|, so the low bits suffice.
  assign diff     = shifted[DIVISOR_W:0] - {1'b0, dmag};
  assign qbit     = (shifted >= {2'b00, dmag});
  assign prem_out = qbit ? diff : shifted[DIVISOR_W:0];

endmodule
`default_nettype wire

// File: rtl/pp_pipeline_accel_divrem_23s_10s_seq.sv
`default_nettype none
// ============================================================================
// Module  : pp_pipeline_accel_divrem_23s_10s_seq
// Purpose : Sequential signed divider, C truncation semantics, 1 bit/cycle.
// Rev     : 1.0
// ============================================================================
module pp_pipeline_accel_divrem_23s_10s_seq
  import pp_pipeline_accel_divrem_pkg::*;
#(
  parameter int DIVIDEND_W = DEF_DIVIDEND_W,
  parameter int DIVISOR_W  = DEF_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] din0,
  input  logic [DIVISOR_W-1:0]  din1,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quot,
  output logic [DIVISOR_W-1:0]  rem,
  output logic                  dz,
  output logic                  ovf
);

  localparam int                  CW       = cnt_width(DIVIDEND_W);
  localparam logic [CW-1:0]       CNT_LAST = CW'(DIVIDEND_W - 1);
  localparam logic [DIVIDEND_W-1:0] MIN_N  = {1'b1, {(DIVIDEND_W-1){1'b0}}};

  state_t                  state, state_n;
  logic [CW-1:0]           cnt;
  logic [DIVIDEND_W-1:0]   dvd;
  logic [DIVISOR_W:0]      prem;
  logic [DIVISOR_W-1:0]    dmag;
  logic [DIVISOR_W-1:0]    lo_l;
  logic                    neg_n, neg_d, dz_l, ovf_l;

  logic [DIVIDEND_W-1:0]   abs_n;
  logic [DIVISOR_W-1:0]    abs_d;
  logic                    ovf_in;
  logic [DIVISOR_W:0]      prem_nxt;
  logic                    qbit;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  // Magnitudes are unsigned, so -MIN maps onto 2^(W-1) without loss.
  assign abs_n  = din0[DIVIDEND_W-1] ? -din0 : din0;
  assign abs_d  = din1[DIVISOR_W-1]  ? -din1 : din1;
  assign ovf_in = (din0 == MIN_N) && (din1 == '1);

  pp_pipeline_accel_divrem_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .prem_in  (prem),
    .bit_in   (dvd[DIVIDEND_W-1]),
    .dmag     (dmag),
    .prem_out (prem_nxt),
    .qbit     (qbit)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (ce) begin
      case (state)
        IDLE:    if (in_valid)     state_n = RUN;
        RUN:     if (cnt == '0)    state_n = FIX;
        FIX:                       state_n = DONE;
        DONE:    if (out_ready)    state_n = IDLE;
        default:                   state_n = IDLE;
      endcase
    end
  end

  // The dividend register doubles as the quotient register: bits leave at
  // the top while quotient bits enter at the bottom.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      dvd   <= '0;
      prem  <= '0;
      dmag  <= '0;
      lo_l  <= '0;
      neg_n <= 1'b0;
      neg_d <= 1'b0;
      dz_l  <= 1'b0;
      ovf_l <= 1'b0;
      quot  <= '0;
      rem   <= '0;
      dz    <= 1'b0;
      ovf   <= 1'b0;
    end else if (ce) begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            neg_n <= din0[DIVIDEND_W-1];
            neg_d <= din1[DIVISOR_W-1];
            dvd   <= abs_n;
            dmag  <= abs_d;
            prem  <= '0;
            lo_l  <= din0[DIVISOR_W-1:0];
            dz_l  <= (din1 == '0);
            ovf_l <= ovf_in;
            cnt   <= CNT_LAST;
          end
        end
        RUN: begin
          prem <= prem_nxt;
          dvd  <= {dvd[DIVIDEND_W-2:0], qbit};
          if (cnt != '0) cnt <= cnt - CW'(1);
        end
        FIX: begin
          dz  <= dz_l;
          ovf <= ovf_l;
          if (dz_l) begin
            quot <= '1;
            rem  <= lo_l;
          end else if (ovf_l) begin
            quot <= MIN_N;
            rem  <= '0;
          end else begin
            quot <= (neg_n ^ neg_d) ? -dvd : dvd;
            rem  <= neg_n ? -prem[DIVISOR_W-1:0] : prem[DIVISOR_W-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pp_pipeline_accel_divrem_23s_10s_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_pp_pipeline_accel_divrem_23s_10s_seq
// Purpose : Directed-vector and randomised self-checking bench for the divider.
// Rev     : 1.0
// ============================================================================
module tb_pp_pipeline_accel_divrem_23s_10s_seq;

  localparam int NW = 23;
  localparam int DW = 10;

  logic          clk = 1'b0;
  logic          reset, ce, in_valid, in_ready, out_valid, out_ready, dz, ovf;
  logic [NW-1:0] din0, quot;
  logic [DW-1:0] din1, rem;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  pp_pipeline_accel_divrem_23s_10s_seq dut (
    .clk       (clk),
    .reset     (reset),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .din0      (din0),
    .din1      (din1),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quot      (quot),
    .rem       (rem),
    .dz        (dz),
    .ovf       (ovf)
  );

  typedef struct {
    int n; int d; int q; int r; bit edz; bit eovf;
  } vec_t;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic longint sq();
    return longint'($signed(quot));
  endfunction

  function automatic longint sr();
    return longint'($signed(rem));
  endfunction

  // Reference: C truncating division with the divider's dz/ovf overrides.
  function automatic void model(input int n, input int d, output int q, output int r,
                                output bit edz, output bit eovf);
    logic [DW-1:0] lo;
    lo   = n[DW-1:0];
    edz  = (d == 0);
    eovf = (n == -4194304) && (d == -1);
    if (edz) begin
      q = -1; r = int'($signed(lo));
    end else if (eovf) begin
      q = -4194304; r = 0;
    end else begin
      q = n / d; r = n % d;
    end
  endfunction

  // Starts and ends on a falling edge; lat counts enabled+stalled edges after accept.
  task automatic do_op(input int n, input int d, input int st_at, input int st_len,
                       output int lat);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    din0 = n[NW-1:0];
    din1 = d[DW-1:0];
    in_valid = 1'b1;
    ce = 1'b1;
    @(posedge clk);
    lat = 0;
    while (lat < 200) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (out_valid) begin
        seen = 1'b1;
        break;
      end
      ce = (lat >= st_at && lat < st_at + st_len) ? 1'b0 : 1'b1;
      @(posedge clk);
      lat++;
    end
    ce = 1'b1;
    if (!seen) begin
      @(negedge clk);
      check("out_valid_timeout", 0, 1);
    end
  endtask

  task automatic finish_op();
    out_ready = 1'b1;
    ce = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("in_ready_after_xfer", in_ready, 1);
    check("out_valid_after_xfer", out_valid, 0);
  endtask

  task automatic check_result(input string tag, input int q, input int r,
                              input bit edz, input bit eovf, input int lat, input int elat);
    check({tag, "_quot"}, sq(), q);
    check({tag, "_rem"}, sr(), r);
    check({tag, "_dz"}, dz, edz);
    check({tag, "_ovf"}, ovf, eovf);
    check({tag, "_lat"}, lat, elat);
  endtask

  initial begin
    vec_t vt[12];
    int lat, q, r;
    bit edz, eovf;
    logic [NW-1:0] rn;
    logic [DW-1:0] rd;
    longint hq, hr;

    vt[0]  = '{1000, 7, 142, 6, 1'b0, 1'b0};
    vt[1]  = '{-1000, 7, -142, -6, 1'b0, 1'b0};
    vt[2]  = '{1000, -7, -142, 6, 1'b0, 1'b0};
    vt[3]  = '{-1000, -7, 142, -6, 1'b0, 1'b0};
    vt[4]  = '{-1, -512, 0, -1, 1'b0, 1'b0};
    vt[5]  = '{-4194304, -1, -4194304, 0, 1'b0, 1'b1};
    vt[6]  = '{4194303, 1, 4194303, 0, 1'b0, 1'b0};
    vt[7]  = '{123, 0, -1, 123, 1'b1, 1'b0};
    vt[8]  = '{-4194304, 0, -1, 0, 1'b1, 1'b0};
    vt[9]  = '{4194303, -512, -8191, 511, 1'b0, 1'b0};
    vt[10] = '{4194303, 511, 8208, 15, 1'b0, 1'b0};
    vt[11] = '{-4194304, 1, -4194304, 0, 1'b0, 1'b0};

    reset = 1'b1; ce = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    din0 = '0; din1 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quot", sq(), 0);
    check("rst_rem", sr(), 0);
    check("rst_dz", dz, 0);
    check("rst_ovf", ovf, 0);
    ce = 1'b1;

    for (int i = 0; i < 12; i++) begin
      do_op(vt[i].n, vt[i].d, 0, 0, lat);
      check_result($sformatf("vec%0d", i), vt[i].q, vt[i].r, vt[i].edz, vt[i].eovf, lat, 24);
      finish_op();
    end

    // Backpressure in DONE: outputs frozen, new request not taken.
    do_op(1000, 7, 0, 0, lat);
    hq = sq(); hr = sr();
    din0 = 23'd5; din1 = 10'd1; in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold_quot", sq(), 142);
      check("hold_rem", sr(), 6);
      check("hold_in_ready", in_ready, 0);
      check("hold_out_valid", out_valid, 1);
    end
    in_valid = 1'b0;
    finish_op();
    check("held_after_idle_quot", sq(), hq);
    check("held_after_idle_rem", sr(), hr);

    // ce dropped for 5 cycles mid-RUN.
    do_op(-1000, 7, 8, 5, lat);
    check_result("ce_stall", -142, -6, 1'b0, 1'b0, lat, 29);
    finish_op();

    // Reset aborts an operation at cycle 12 of RUN.
    @(negedge clk);
    din0 = 23'd1000; din1 = 10'd7; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (11) @(posedge clk);
    @(negedge clk);
    check("pre_rst_in_ready", in_ready, 0);
    reset = 1'b1;
    #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_in_ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    do_op(500, -3, 0, 0, lat);
    check_result("post_rst", -166, 2, 1'b0, 1'b0, lat, 24);
    finish_op();

    // Randomised operands with ce throttling and output backpressure.
    for (int i = 0; i < 300; i++) begin
      int n, d, sl;
      rn = NW'($urandom);
      rd = DW'($urandom);
      if ($urandom_range(0, 7) == 0) rd = DW'($urandom_range(0, 3));
      n = int'($signed(rn));
      d = int'($signed(rd));
      sl = $urandom_range(0, 4);
      model(n, d, q, r, edz, eovf);
      do_op(n, d, $urandom_range(0, 20), sl, lat);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      check_result($sformatf("rnd%0d", i), q, r, edz, eovf, lat, 24 + sl);
      finish_op();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
